// File: rtl/subtractor_serial_16bit_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package subtractor_serial_16bit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder shared by the serial arithmetic units.
// Ports: a, b, cin in; sum, cout out.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/subtractor_serial_16bit.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, one bit/clock.
// Ports: clk, rst, start, A, B, Bin in; busy, done, D, Bout, overflow out.
module subtractor_serial_16bit
   import subtractor_serial_16bit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             overflow
);

   state_t           st;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             a_msb;
   logic             b_msb;
   logic             nb;
   logic             s;
   logic             co;
   logic             last;

   // Subtraction as A + ~B + ~Bin through the shared adder.
   assign nb   = ~b_sh[0];
   assign last = (cnt == CNT_W'(WIDTH - 1));

   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (nb),
      .cin  (carry),
      .sum  (s),
      .cout (co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         D        <= '0;
         Bout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         unique case (st)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  st       <= RUN;
                  busy     <= 1'b1;
                  a_sh     <= A;
                  b_sh     <= B;
                  a_msb    <= A[WIDTH-1];
                  b_msb    <= B[WIDTH-1];
                  carry    <= ~Bin;
                  cnt      <= '0;
                  D        <= '0;
                  Bout     <= 1'b0;
                  overflow <= 1'b0;
               end else begin
                  st <= IDLE;
               end
            end
            RUN: begin
               // Sum enters at the MSB so bit i lands at D[i].
               D     <= {s, D[WIDTH-1:1]};
               carry <= co;
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  st       <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  Bout     <= ~co;
                  overflow <= (a_msb != b_msb) && (s != a_msb);
               end
            end
            default: begin
               st   <= IDLE;
               busy <= 1'b0;
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_subtractor_serial_16bit.sv
// Directed and random checks for subtractor_serial_16bit.
// Drives and samples on the falling clock edge.
module tb_subtractor_serial_16bit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        Bin;
   logic        busy;
   logic        done;
   logic [15:0] D;
   logic        Bout;
   logic        overflow;

   int nchk;
   int nfail;
   logic prev_busy;

   subtractor_serial_16bit #(.WIDTH(16), .CNT_W(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .A        (A),
      .B        (B),
      .Bin      (Bin),
      .busy     (busy),
      .done     (done),
      .D        (D),
      .Bout     (Bout),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // done must always follow a busy cycle
   always @(negedge clk) begin
      if (done) begin
         nchk++;
         if (prev_busy !== 1'b1) begin
            nfail++;
            $display("FAIL done_no_start: done=1 prev_busy=%b required 1",
                     prev_busy);
         end
      end
      prev_busy = busy;
   end

   task automatic do_start(input logic [15:0] a, input logic [15:0] b,
                           input logic bin);
      @(negedge clk);
      A = a; B = b; Bin = bin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at first negedge after acceptance; returns cycles to done.
   task automatic wait_done(output int lat, output int nbusy);
      lat = 1;
      nbusy = 0;
      while (done !== 1'b1 && lat <= 40) begin
         if (busy === 1'b1) nbusy++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
      repeat (2) @(negedge clk);
      nchk++;
      if ({busy, done, D, Bout, overflow} !== 19'd0) begin
         nfail++;
         $display("FAIL reset: got b=%b d=%b D=%h bo=%b ov=%b required all 0",
                  busy, done, D, Bout, overflow);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      int lat, nb;
      do_start(16'h0005, 16'h0003, 1'b0);
      wait_done(lat, nb);
      nchk++;
      if (lat != 17) begin
         nfail++;
         $display("FAIL basic_latency: got %0d required 17", lat);
      end
      nchk++;
      if (nb != 16) begin
         nfail++;
         $display("FAIL basic_busy: got %0d cycles required 16", nb);
      end
      nchk++;
      if ({D, Bout, overflow} !== {16'h0002, 1'b0, 1'b0}) begin
         nfail++;
         $display("FAIL basic_result: got %h/%b/%b required 0002/0/0",
                  D, Bout, overflow);
      end
      nchk++;
      if (busy !== 1'b0) begin
         nfail++;
         $display("FAIL basic_busy_at_done: got %b required 0", busy);
      end
      @(negedge clk);
      nchk++;
      if (done !== 1'b0 || D !== 16'h0002) begin
         nfail++;
         $display("FAIL basic_hold: got done=%b D=%h required 0/0002",
                  done, D);
      end
   endtask

   task automatic test_borrow;
      int lat, nb;
      do_start(16'h0000, 16'h0001, 1'b0);
      wait_done(lat, nb);
      nchk++;
      if ({D, Bout, overflow} !== {16'hFFFF, 1'b1, 1'b0}) begin
         nfail++;
         $display("FAIL borrow_a: got %h/%b/%b required ffff/1/0",
                  D, Bout, overflow);
      end
      do_start(16'h1234, 16'h1234, 1'b1);
      wait_done(lat, nb);
      nchk++;
      if ({D, Bout, overflow} !== {16'hFFFF, 1'b1, 1'b0}) begin
         nfail++;
         $display("FAIL borrow_bin: got %h/%b/%b required ffff/1/0",
                  D, Bout, overflow);
      end
   endtask

   task automatic test_overflow;
      int lat, nb;
      do_start(16'h8000, 16'h0001, 1'b0);
      wait_done(lat, nb);
      nchk++;
      if ({D, Bout, overflow} !== {16'h7FFF, 1'b0, 1'b1}) begin
         nfail++;
         $display("FAIL ovf_neg: got %h/%b/%b required 7fff/0/1",
                  D, Bout, overflow);
      end
      do_start(16'h7FFF, 16'hFFFF, 1'b0);
      wait_done(lat, nb);
      nchk++;
      if ({D, Bout, overflow} !== {16'h8000, 1'b1, 1'b1}) begin
         nfail++;
         $display("FAIL ovf_pos: got %h/%b/%b required 8000/1/1",
                  D, Bout, overflow);
      end
   endtask

   task automatic test_back_to_back;
      int lat, nb;
      do_start(16'h00FF, 16'h000F, 1'b0);
      repeat (4) @(negedge clk);
      A = 16'hAAAA; B = 16'h1234; Bin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, nb);
      nchk++;
      if (lat != 12 || D !== 16'h00F0) begin
         nfail++;
         $display("FAIL ignore_start: got lat=%0d D=%h required 12/00f0",
                  lat, D);
      end
      A = 16'h0010; B = 16'h0001; Bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nchk++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         nfail++;
         $display("FAIL b2b_reenter: got busy=%b done=%b required 1/0",
                  busy, done);
      end
      wait_done(lat, nb);
      nchk++;
      if (lat != 17 || D !== 16'h000F) begin
         nfail++;
         $display("FAIL b2b_result: got lat=%0d D=%h required 17/000f",
                  lat, D);
      end
   endtask

   task automatic test_reset_midrun;
      int lat, nb;
      int seen;
      do_start(16'hFFFF, 16'h0001, 1'b0);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      nchk++;
      if ({busy, done, D, Bout, overflow} !== 19'd0) begin
         nfail++;
         $display("FAIL midrun_reset: got b=%b d=%b D=%h bo=%b ov=%b required 0",
                  busy, done, D, Bout, overflow);
      end
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      nchk++;
      if (seen != 0) begin
         nfail++;
         $display("FAIL midrun_quiet: got %0d active cycles required 0", seen);
      end
      do_start(16'h0003, 16'h0002, 1'b0);
      wait_done(lat, nb);
      nchk++;
      if (lat != 17 || D !== 16'h0001) begin
         nfail++;
         $display("FAIL midrun_restart: got lat=%0d D=%h required 17/0001",
                  lat, D);
      end
   endtask

   task automatic test_random;
      int lat, nb;
      logic [15:0] a, b;
      logic bin;
      logic [16:0] exp17;
      logic eov;
      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         bin = 1'($urandom);
         exp17 = {1'b0, a} - {1'b0, b} - {16'd0, bin};
         eov = (a[15] != b[15]) && (exp17[15] != a[15]);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_start(a, b, bin);
         A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
         wait_done(lat, nb);
         nchk++;
         if (lat != 17 || {D, Bout, overflow} !== {exp17[15:0], exp17[16], eov})
         begin
            nfail++;
            $display("FAIL rand_%0d: %h-%h-%b got lat=%0d %h/%b/%b required 17 %h/%b/%b",
                     i, a, b, bin, lat, D, Bout, overflow,
                     exp17[15:0], exp17[16], eov);
         end
      end
   endtask

   initial begin
      nchk = 0;
      nfail = 0;
      prev_busy = 1'b0;
      test_reset;
      test_basic;
      test_borrow;
      test_overflow;
      test_back_to_back;
      test_reset_midrun;
      test_random;
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
